instr_encoder_loader: RTL

//  Inverse of the immediate generator: packs decoded instruction fields (format, opcode, funct,

---
 rtl/instr_encoder_loader.sv | 127 ++++++++++++
 1 files changed

// File: rtl/instr_encoder_loader.sv
// Packs decoded RV32I fields into instruction words, range-checks the immediate,
// and streams valid words into instruction memory starting at BASE_ADDR.
module instr_encoder_loader #(
    parameter int unsigned       ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;

    localparam logic [ADDR_W:0] LAST_COUNT = {1'b0, {ADDR_W{1'b1}}};

    localparam logic [1:0] E_NONE  = 2'd0;
    localparam logic [1:0] E_RANGE = 2'd1;
    localparam logic [1:0] E_ODD   = 2'd2;
    localparam logic [1:0] E_FMT   = 2'd3;

    logic [1:0]      state;
    logic [31:0]     enc_word;
    logic [1:0]      chk_code;
    logic            accept;
    logic [ADDR_W:0] committed;

    logic fits_12;
    logic fits_13;
    logic fits_21;

    // Signed-range checks: all bits above the field's sign bit must match it.
    assign fits_12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits_13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fits_21 = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        enc_word = '0;
        chk_code = E_NONE;
        case (fmt)
            3'd0: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
            3'd1: begin
                enc_word = {imm[11:0], rs1, funct3, rd, opcode};
                if (!fits_12) chk_code = E_RANGE;
            end
            3'd2: begin
                enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                if (!fits_12) chk_code = E_RANGE;
            end
            3'd3: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                if (imm[0])        chk_code = E_ODD;
                else if (!fits_13) chk_code = E_RANGE;
            end
            3'd4: begin
                enc_word = {imm[31:12], rd, opcode};
                if (|imm[11:0]) chk_code = E_RANGE;
            end
            3'd5: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                if (imm[0])        chk_code = E_ODD;
                else if (!fits_21) chk_code = E_RANGE;
            end
            default: chk_code = E_FMT;
        endcase
    end

    assign in_ready  = (state == S_LOAD) & ~start;
    assign accept    = in_valid & in_ready;
    assign done      = (state == S_FULL);
    // Count as it will stand after any pending write commits at this edge.
    assign committed = word_count + (ADDR_W+1)'(mem_we);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            mem_we     <= 1'b0;
            mem_addr   <= BASE_ADDR;
            mem_wdata  <= '0;
            word_count <= '0;
            err        <= 1'b0;
            err_code   <= E_NONE;
        end else if (start) begin
            state      <= S_LOAD;
            mem_we     <= 1'b0;
            mem_addr   <= BASE_ADDR;
            word_count <= '0;
            err        <= 1'b0;
            err_code   <= E_NONE;
        end else begin
            mem_we <= 1'b0;
            if (mem_we) begin
                mem_addr   <= mem_addr + ADDR_W'(1);
                word_count <= word_count + (ADDR_W+1)'(1);
            end
            if (accept) begin
                if (chk_code != E_NONE) begin
                    err <= 1'b1;
                    if (!err) err_code <= chk_code;
                end else begin
                    mem_we    <= 1'b1;
                    mem_wdata <= enc_word;
                    if (committed == LAST_COUNT) state <= S_FULL;
                end
            end
        end
    end

endmodule
